imem_prog_encoder: RTL and testbench
====================================

Name: imem_prog_encoder

Overview:
- Streaming RV32I instruction encoder and instruction-memory loader; the inverse of the main control decoder.
- Accepts instruction fields over a valid/ready handshake and packs them into 32-bit RV32I words.
- Writes words to consecutive instruction-memory addresses, so the single-cycle core can be loaded on-chip with programs for self-test.
- Sits between the test sequencer and the instruction-memory write port.

Parameters:
- ADDR_W, 10, log2 of instruction-memory depth in words.
- BASE_ADDR, 32'h0, byte address of the first written word.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle pulse; begins a load session.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_last  in  1  bundle is the final instruction of the session.
- in_type  in  3  instruction class: 0 R, 1 I, 2 LW, 3 JALR, 4 S, 5 B, 6 U, 7 J.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used by R only.
- in_imm  in  32  signed immediate / byte offset; for U, the full 32-bit value.
- mem_we  out  1  instruction-memory write strobe.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  encoded word.
- word_count  out  ADDR_W+1  words written this session.
- err  out  1  one-cycle pulse: bundle rejected.
- err_sticky  out  1  set on any rejection; cleared by start.
- full  out  1  session ended on memory full.
- done  out  1  one-cycle pulse: session finished.

Behaviour:
- Reset (rst==0 at a clock edge):
  - All outputs 0 (mem_addr 0), state IDLE, index 0.
  - Any pending write is dropped; applies mid-session as well.
- Opcodes:
  - R 0110011, I 0010011, LW 0000011, JALR 1100111.
  - S 0100011, B 1100011, U 0110111, J 1101111.
- Encoding is standard RV32I:
  - R: funct7|rs2|rs1|f3|rd|op.
  - I/LW/JALR: imm[11:0]|rs1|f3|rd|op.
  - S: imm[11:5]|rs2|rs1|f3|imm[4:0]|op.
  - B: imm[12]|imm[10:5]|rs2|rs1|f3|imm[4:1]|imm[11]|op.
  - U: imm[31:12]|rd|op.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - Unused fields for a class are ignored.
- Legality checks (rejection when violated):
  - I/LW/JALR/S: imm in [-2048, 2047].
  - B: imm in [-4096, 4094] and imm[0]==0.
  - J: imm in [-2^20, 2^20-2] and imm[0]==0.
  - U: imm[11:0]==0.
  - R: always legal.
- FSM states: IDLE, ACTIVE, FINISH.
  - IDLE: in_ready=0. start -> ACTIVE; index=0, err_sticky=0, full=0, word_count=0.
  - ACTIVE: in_ready=1 while index < 2^ADDR_W; start is ignored.
  - FINISH: done=1 for exactly one cycle -> IDLE.
- Handshake and write timing:
  - A bundle is accepted at an edge where in_valid & in_ready. Fields are registered at that edge.
  - In the following cycle, mem_we=1 with mem_wdata = encoded word and mem_addr = BASE_ADDR + 4*index. The write commits at the next edge, where index and word_count increment.
  - Latency is 1 cycle from acceptance to strobe. Throughput is 1 word/cycle; back-to-back accepts produce back-to-back strobes.
- Rejected bundle:
  - No write; mem_we=0 in that slot; index unchanged.
  - err=1 for one cycle (same slot as the write would have been); err_sticky set.
- in_last accepted (legal or rejected): ACTIVE -> FINISH after its write slot. in_ready=0 from the edge after acceptance.
- Memory full: when the accepted write brings index to 2^ADDR_W, in_ready drops, full=1, then FINISH. Inputs presented while full are not accepted.
- Simultaneous in_last and full: a single FINISH; full=1.
- mem_addr holds its last value when mem_we=0; word_count holds until the next start.

Test Plan:
- start; I {rd=1, rs1=0, f3=0, imm=5} -> mem_we one cycle after accept, addr 0x0, wdata 0x00500093.
- Back-to-back R {rd=3, rs1=1, rs2=2, f3=0, f7=0}, then S {rs1=1, rs2=2, f3=2, imm=8} -> 0x002081B3 @0x0, 0x0020A423 @0x4 on consecutive cycles.
- B {rs1=1, rs2=2, f3=0, imm=-4}, J {rd=1, imm=8}, U {rd=5, imm=0x12345000, in_last} -> 0xFE208EE3, 0x008000EF, 0x123452B7; then done pulse; word_count=3.
- B imm=3, then B imm=5000, then legal I -> two err pulses, no writes for the illegal pair, err_sticky=1, I word written at addr 0x0.
- ADDR_W=2, stream 5 legal words -> 4 writes (0x0..0xC), in_ready low after the 4th accept, full=1, done; 5th bundle not consumed.
- rst low during a streaming session -> next cycle mem_we=0, all outputs 0, IDLE; a new start restarts at BASE_ADDR.

Source files
------------

// File: rtl/imem_prog_encoder.sv
// imem_prog_encoder: packs RV32I field bundles into instruction words and
// streams them into consecutive instruction-memory addresses.
module imem_prog_encoder #(
    parameter int          ADDR_W    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_type,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W:0]   word_count,
    output logic              err,
    output logic              err_sticky,
    output logic              full,
    output logic              done
);
    localparam int            CW    = ADDR_W + 1;
    localparam logic [CW-1:0] DEPTH = CW'(1) << ADDR_W;

    typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;

    state_t        r_state;
    logic          r_slot;
    logic          r_slot_last;
    logic          w_accept;
    logic          w_legal;
    logic          w_i_ok;
    logic          w_b_ok;
    logic          w_j_ok;
    logic          w_full_now;
    logic          w_end;
    logic [31:0]   w_word;
    logic [31:0]   w_wr_addr;
    logic [CW-1:0] w_committed;
    logic [CW-1:0] w_pending;

    // A range check on a signed value reduces to "all upper bits equal".
    assign w_i_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
    assign w_b_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
    assign w_j_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

    always_comb begin
        w_legal = 1'b1;
        w_word  = '0;
        case (in_type)
            3'd0: w_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'b0110011};
            3'd1: begin
                w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                w_legal = w_i_ok;
            end
            3'd2: begin
                w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                w_legal = w_i_ok;
            end
            3'd3: begin
                w_word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b1100111};
                w_legal = w_i_ok;
            end
            3'd4: begin
                w_word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                w_legal = w_i_ok;
            end
            3'd5: begin
                w_word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                           in_imm[4:1], in_imm[11], 7'b1100011};
                w_legal = w_b_ok;
            end
            3'd6: begin
                w_word  = {in_imm[31:12], in_rd, 7'b0110111};
                w_legal = ~(|in_imm[11:0]);
            end
            default: begin
                w_word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
                w_legal = w_j_ok;
            end
        endcase
    end

    // Committed count includes the write in flight, so back-to-back accepts
    // get consecutive addresses and the ready decision sees every pending word.
    assign w_accept    = in_valid & in_ready;
    assign w_committed = word_count + CW'(mem_we);
    assign w_pending   = w_committed + CW'(w_accept & w_legal);
    assign w_full_now  = mem_we & (w_committed == DEPTH);
    assign w_end       = r_slot & (r_slot_last | w_full_now);
    assign w_wr_addr   = BASE_ADDR + (32'(w_committed) << 2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_slot      <= 1'b0;
            r_slot_last <= 1'b0;
            in_ready    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            word_count  <= '0;
            err         <= 1'b0;
            err_sticky  <= 1'b0;
            full        <= 1'b0;
            done        <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            err    <= 1'b0;
            done   <= 1'b0;
            r_slot <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state    <= ACTIVE;
                        in_ready   <= 1'b1;
                        word_count <= '0;
                        err_sticky <= 1'b0;
                        full       <= 1'b0;
                    end
                end
                ACTIVE: begin
                    word_count <= w_committed;
                    in_ready   <= in_ready & ~(w_accept & in_last) & (w_pending < DEPTH);
                    if (w_accept) begin
                        r_slot      <= 1'b1;
                        r_slot_last <= in_last;
                        mem_we      <= w_legal;
                        err         <= ~w_legal;
                        err_sticky  <= err_sticky | ~w_legal;
                        if (w_legal) begin
                            mem_addr  <= w_wr_addr;
                            mem_wdata <= w_word;
                        end
                    end
                    if (w_full_now) full <= 1'b1;
                    if (w_end) begin
                        r_state  <= FINISH;
                        done     <= 1'b1;
                        in_ready <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_prog_encoder.sv
// tb_imem_prog_encoder: directed vectors for the RV32I encoder/loader, with a
// full-depth instance (ADDR_W=10) and a tiny one (ADDR_W=2) for the full case.
module tb_imem_prog_encoder;
    typedef struct packed {
        logic [2:0]  ty;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    localparam int NV = 23;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        valid_a = 1'b0, valid_b = 1'b0;
    logic        last = 1'b0;
    logic [2:0]  ty = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [2:0]  f3 = '0;
    logic [6:0]  f7 = '0;
    logic [31:0] imm = '0;

    logic        a_in_ready, a_mem_we, a_err, a_err_sticky, a_full, a_done;
    logic [31:0] a_mem_addr, a_mem_wdata;
    logic [10:0] a_word_count;
    logic        b_in_ready, b_mem_we, b_err, b_err_sticky, b_full, b_done;
    logic [31:0] b_mem_addr, b_mem_wdata;
    logic [2:0]  b_word_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_errs = 0, a_dones = 0, b_dones = 0;
    logic [31:0] la_addr[$], la_data[$], lb_addr[$], lb_data[$];
    int la_cyc[$];
    vec_t tbl[NV];
    vec_t fv[5];

    always #5 clk = ~clk;

    imem_prog_encoder #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(valid_a), .in_ready(a_in_ready),
        .in_last(last), .in_type(ty), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
        .in_funct3(f3), .in_funct7(f7), .in_imm(imm), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .word_count(a_word_count),
        .err(a_err), .err_sticky(a_err_sticky), .full(a_full), .done(a_done));

    imem_prog_encoder #(.ADDR_W(2), .BASE_ADDR(32'h0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .in_valid(valid_b), .in_ready(b_in_ready),
        .in_last(last), .in_type(ty), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2),
        .in_funct3(f3), .in_funct7(f7), .in_imm(imm), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .word_count(b_word_count),
        .err(b_err), .err_sticky(b_err_sticky), .full(b_full), .done(b_done));

    always @(negedge clk) begin
        cyc++;
        if (a_mem_we) begin
            la_addr.push_back(a_mem_addr);
            la_data.push_back(a_mem_wdata);
            la_cyc.push_back(cyc);
        end
        if (b_mem_we) begin
            lb_addr.push_back(b_mem_addr);
            lb_data.push_back(b_mem_wdata);
        end
        if (a_err) a_errs++;
        if (a_done) a_dones++;
        if (b_done) b_dones++;
    end

    function automatic vec_t mk(input int t, input int d, input int s1, input int s2, input int fn3,
                                input int fn7, input logic [31:0] im, input logic lg, input logic [31:0] w);
        vec_t v;
        v.ty = 3'(t); v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
        v.f3 = 3'(fn3); v.f7 = 7'(fn7); v.imm = im; v.legal = lg; v.word = w;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_start(input logic sel);
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    // Presents a bundle and returns just after the edge that accepted it.
    task automatic send(input logic sel, input vec_t v, input logic lst, input int budget, output logic ok);
        ok = 1'b0;
        @(negedge clk);
        ty = v.ty; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; f3 = v.f3; f7 = v.f7; imm = v.imm; last = lst;
        if (sel) valid_b = 1'b1; else valid_a = 1'b1;
        for (int n = 0; n < budget; n++) begin
            if (sel ? b_in_ready : a_in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic release_bus();
        @(negedge clk);
        valid_a = 1'b0;
        valid_b = 1'b0;
        last = 1'b0;
    endtask

    task automatic wait_done_a(input int budget, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (a_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic ok;
        int na, ea, da, nb, db, k, prev, nlegal;
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 32'd5, 1, 32'h00500093);
        tbl[1]  = mk(0, 3, 1, 2, 0, 0, 0, 1, 32'h002081B3);
        tbl[2]  = mk(4, 9, 1, 2, 2, 0, 32'd8, 1, 32'h0020A423);
        tbl[3]  = mk(0, 5, 6, 7, 0, 7'h20, 0, 1, 32'h407302B3);
        tbl[4]  = mk(1, 1, 2, 0, 0, 0, -2048, 1, 32'h80010093);
        tbl[5]  = mk(1, 1, 0, 0, 0, 0, 32'd2047, 1, 32'h7FF00093);
        tbl[6]  = mk(1, 1, 0, 0, 0, 0, 32'd2048, 0, 0);
        tbl[7]  = mk(2, 10, 2, 0, 2, 0, 32'd12, 1, 32'h00C12503);
        tbl[8]  = mk(3, 0, 1, 0, 0, 0, 0, 1, 32'h00008067);
        tbl[9]  = mk(4, 0, 2, 5, 2, 0, -4, 1, 32'hFE512E23);
        tbl[10] = mk(5, 0, 0, 0, 0, 0, 32'd4094, 1, 32'h7E000FE3);
        tbl[11] = mk(5, 0, 0, 0, 0, 0, -4096, 1, 32'h80000063);
        tbl[12] = mk(5, 0, 0, 0, 0, 0, 32'd4096, 0, 0);
        tbl[13] = mk(5, 0, 0, 0, 0, 0, 32'd2048, 1, 32'h000000E3);
        tbl[14] = mk(7, 0, 0, 0, 0, 0, 32'hFFF00000, 1, 32'h8000006F);
        tbl[15] = mk(7, 0, 0, 0, 0, 0, 32'h00100000, 0, 0);
        tbl[16] = mk(7, 1, 0, 0, 0, 0, 32'h000FF000, 1, 32'h000FF0EF);
        tbl[17] = mk(7, 1, 0, 0, 0, 0, 32'h00000800, 1, 32'h001000EF);
        tbl[18] = mk(6, 1, 0, 0, 0, 0, 32'h00001001, 0, 0);
        tbl[19] = mk(6, 1, 0, 0, 0, 0, 32'hFFFFF000, 1, 32'hFFFFF0B7);
        tbl[20] = mk(5, 0, 1, 2, 0, 0, -4, 1, 32'hFE208EE3);
        tbl[21] = mk(7, 1, 0, 0, 0, 0, 32'd8, 1, 32'h008000EF);
        tbl[22] = mk(6, 5, 0, 0, 0, 0, 32'h12345000, 1, 32'h123452B7);
        fv[0] = mk(1, 1, 0, 0, 0, 0, 32'd1, 1, 32'h00100093);
        fv[1] = mk(1, 1, 0, 0, 0, 0, 32'd2, 1, 32'h00200093);
        fv[2] = mk(1, 1, 0, 0, 0, 0, 32'd3, 1, 32'h00300093);
        fv[3] = mk(1, 1, 0, 0, 0, 0, 32'd4, 1, 32'h00400093);
        fv[4] = mk(1, 1, 0, 0, 0, 0, 32'd5, 1, 32'h00500093);

        repeat (3) @(negedge clk);
        chk("rst mem_we", a_mem_we, 0);
        chk("rst mem_addr", a_mem_addr, 0);
        chk("rst mem_wdata", a_mem_wdata, 0);
        chk("rst word_count", a_word_count, 0);
        chk("rst in_ready", a_in_ready, 0);
        chk("rst err", a_err, 0);
        chk("rst err_sticky", a_err_sticky, 0);
        chk("rst full", a_full, 0);
        chk("rst done", a_done, 0);
        chk("rst b in_ready", b_in_ready, 0);
        rst = 1'b1;

        // Single I word: strobe exactly one cycle after accept, then done.
        do_start(0);
        chk("ready after start", a_in_ready, 1);
        send(0, tbl[0], 1, 10, ok);
        chk("single accept", ok, 1);
        @(negedge clk);
        valid_a = 1'b0;
        last = 1'b0;
        chk("single mem_we", a_mem_we, 1);
        chk("single addr", a_mem_addr, 32'h0);
        chk("single wdata", a_mem_wdata, 32'h00500093);
        chk("single ready after last", a_in_ready, 0);
        @(negedge clk);
        chk("single we drops", a_mem_we, 0);
        chk("single done", a_done, 1);
        chk("single word_count", a_word_count, 1);
        @(negedge clk);
        chk("single done one cycle", a_done, 0);

        // Table session streamed back-to-back.
        na = la_addr.size(); ea = a_errs; da = a_dones;
        do_start(0);
        for (int i = 0; i < NV; i++) begin
            send(0, tbl[i], 1'(i == NV - 1), 10, ok);
            chk("table accept", ok, 1);
        end
        release_bus();
        wait_done_a(20, ok);
        chk("table done seen", ok, 1);
        @(posedge clk);
        k = na; prev = -2; nlegal = 0;
        for (int i = 0; i < NV; i++) begin
            if (tbl[i].legal) begin
                if (k < la_addr.size()) begin
                    chk($sformatf("table[%0d] addr", i), la_addr[k], 32'((k - na) * 4));
                    chk($sformatf("table[%0d] wdata", i), la_data[k], tbl[i].word);
                    if (prev == i - 1 && k > na)
                        chk($sformatf("table[%0d] b2b", i), 32'(la_cyc[k] - la_cyc[k-1]), 1);
                end
                prev = i; k++; nlegal++;
            end
        end
        chk("table write count", 32'(la_addr.size() - na), 32'(nlegal));
        chk("table err pulses", 32'(a_errs - ea), 32'(NV - nlegal));
        chk("table err_sticky", a_err_sticky, 1);
        chk("table word_count", a_word_count, 32'(nlegal));
        chk("table full", a_full, 0);
        chk("table done pulses", 32'(a_dones - da), 1);

        // Two illegal B bundles followed by a legal I.
        na = la_addr.size(); ea = a_errs;
        do_start(0);
        send(0, mk(5, 0, 1, 2, 0, 0, 32'd3, 0, 0), 0, 10, ok);
        chk("ill accept 1", ok, 1);
        send(0, mk(5, 0, 1, 2, 0, 0, 32'd5000, 0, 0), 0, 10, ok);
        chk("ill accept 2", ok, 1);
        send(0, tbl[0], 1, 10, ok);
        chk("ill accept 3", ok, 1);
        release_bus();
        wait_done_a(20, ok);
        chk("ill done seen", ok, 1);
        @(posedge clk);
        chk("ill err pulses", 32'(a_errs - ea), 2);
        chk("ill write count", 32'(la_addr.size() - na), 1);
        if (la_addr.size() > na) begin
            chk("ill addr", la_addr[na], 32'h0);
            chk("ill wdata", la_data[na], 32'h00500093);
        end
        chk("ill err_sticky", a_err_sticky, 1);
        chk("ill word_count", a_word_count, 1);

        // Reset mid-session drops the pending write; restart at base.
        do_start(0);
        chk("start clears err_sticky", a_err_sticky, 0);
        send(0, tbl[0], 0, 10, ok);
        chk("rs accept 1", ok, 1);
        send(0, tbl[1], 0, 10, ok);
        chk("rs accept 2", ok, 1);
        @(negedge clk);
        rst = 1'b0;
        valid_a = 1'b0;
        chk("rs pre we", a_mem_we, 1);
        chk("rs pre addr", a_mem_addr, 32'h4);
        @(negedge clk);
        chk("rs mem_we", a_mem_we, 0);
        chk("rs mem_addr", a_mem_addr, 0);
        chk("rs mem_wdata", a_mem_wdata, 0);
        chk("rs word_count", a_word_count, 0);
        chk("rs in_ready", a_in_ready, 0);
        chk("rs done", a_done, 0);
        rst = 1'b1;
        do_start(0);
        send(0, tbl[5], 1, 10, ok);
        chk("rs restart accept", ok, 1);
        @(negedge clk);
        valid_a = 1'b0;
        last = 1'b0;
        chk("rs restart we", a_mem_we, 1);
        chk("rs restart addr", a_mem_addr, 32'h0);
        chk("rs restart wdata", a_mem_wdata, 32'h7FF00093);
        wait_done_a(10, ok);
        chk("rs restart done", ok, 1);

        // Small instance: four words fill memory, the fifth is refused.
        nb = lb_addr.size(); db = b_dones;
        do_start(1);
        for (int i = 0; i < 4; i++) begin
            send(1, fv[i], 0, 10, ok);
            chk("full accept", ok, 1);
        end
        @(negedge clk);
        chk("full ready drop", b_in_ready, 0);
        chk("full 4th we", b_mem_we, 1);
        chk("full 4th addr", b_mem_addr, 32'hC);
        send(1, fv[4], 0, 6, ok);
        chk("full 5th refused", ok, 0);
        release_bus();
        @(posedge clk);
        chk("full write count", 32'(lb_addr.size() - nb), 4);
        for (int i = 0; i < 4; i++) begin
            if (nb + i < lb_addr.size()) begin
                chk($sformatf("full[%0d] addr", i), lb_addr[nb+i], 32'(i * 4));
                chk($sformatf("full[%0d] wdata", i), lb_data[nb+i], fv[i].word);
            end
        end
        chk("full flag", b_full, 1);
        chk("full done pulses", 32'(b_dones - db), 1);
        chk("full word_count", b_word_count, 4);
        chk("full ready idle", b_in_ready, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
